cmd_scheduler: RTL

CMD_SCHEDULER -- requirements
Module: cmd_scheduler

---
 rtl/cmd_pkg.sv | 28 ++
 rtl/cmd_fifo.sv | 51 +++++
 rtl/cmd_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// cmd_pkg: command record, staging field addresses and scheduler states
package cmd_pkg;
  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] dfreq;
    logic [31:0] drate;
    logic [47:0] tstart;
    logic [1:0]  typ;
    logic [15:0] n_imp;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } cmd_t;
  localparam logic [3:0] A_FREQ_LO  = 4'd0;
  localparam logic [3:0] A_FREQ_HI  = 4'd1;
  localparam logic [3:0] A_DFREQ_LO = 4'd2;
  localparam logic [3:0] A_DFREQ_HI = 4'd3;
  localparam logic [3:0] A_DRATE    = 4'd4;
  localparam logic [3:0] A_TS_LO    = 4'd5;
  localparam logic [3:0] A_TS_HI    = 4'd6;
  localparam logic [3:0] A_TYPE_N   = 4'd7;
  localparam logic [3:0] A_TI       = 4'd8;
  localparam logic [3:0] A_TP       = 4'd9;
  localparam logic [3:0] A_TB1      = 4'd10;
  localparam logic [3:0] A_TB2      = 4'd11;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, HOLD} state_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: circular command queue with a registered head output
module cmd_fifo #(
  parameter int W = 322,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_data;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_data;
  // pointers wrap naturally at the power-of-two depth; flush drops everything
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_data;
  end
  // head register trails the read pointer by one cycle
  always_ff @(posedge clk) begin
    r_data <= r_mem[r_rd];
  end
endmodule

// File: rtl/cmd_scheduler.sv
// cmd_scheduler: stages host commands, queues them and issues each one LEAD ticks before its start time
module cmd_scheduler
  import cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [47:0] LEAD = 48'd480
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] TIME,
  input  logic        HOST_WR,
  input  logic [3:0]  HOST_ADDR,
  input  logic [31:0] HOST_DATA,
  input  logic        HOST_COMMIT,
  input  logic        FLUSH,
  input  logic        BUSY,
  output logic        WR_DATA,
  output logic [47:0] MEM_DDS_freq,
  output logic [47:0] MEM_DDS_delta_freq,
  output logic [31:0] MEM_DDS_delta_rate,
  output logic [47:0] MEM_TIME_START,
  output logic [15:0] MEM_N_impuls,
  output logic [1:0]  MEM_TYPE_impulse,
  output logic [31:0] MEM_Interval_Ti,
  output logic [31:0] MEM_Interval_Tp,
  output logic [31:0] MEM_Tblank1,
  output logic [31:0] MEM_Tblank2,
  output logic [2:0]  COUNT,
  output logic        FULL,
  output logic        EMPTY,
  output logic        OVF,
  output logic        LATE
);
  localparam int AW = $clog2(DEPTH);
  cmd_t        r_stage;
  cmd_t        r_mem;
  cmd_t        w_head;
  state_t      r_state;
  logic [47:0] r_last;
  logic        r_wr;
  logic        r_ovf;
  logic        r_late;
  logic        r_stall;
  logic [AW:0] w_count;
  logic [47:0] w_t;
  logic [48:0] w_sum;
  logic        w_late;
  logic        w_go;
  logic        w_push;
  logic        w_pop;
  logic        w_unused_time;
  assign w_t           = TIME[47:0];
  assign w_unused_time = ^TIME[63:48];
  assign w_sum         = {1'b0, w_t} + {1'b0, LEAD};
  assign w_late        = w_head.tstart <= w_t;
  assign w_go          = w_sum >= {1'b0, w_head.tstart};
  assign w_push        = HOST_COMMIT & ~FULL & ~FLUSH;
  // the head register lags a pop by a cycle, so r_stall skips the stale head
  assign w_pop         = (r_state == WAIT) & ~r_stall & ~FLUSH & (w_late | w_go);
  cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK), .rst(RESET), .i_flush(FLUSH), .i_push(w_push), .i_pop(w_pop),
    .i_data(r_stage), .o_data(w_head), .o_count(w_count), .o_full(FULL), .o_empty(EMPTY)
  );
  // host staging fields; a commit in the same cycle pushes the old contents
  always_ff @(posedge CLK) begin
    if (RESET) r_stage <= '0;
    else if (HOST_WR)
      case (HOST_ADDR)
        A_FREQ_LO:  r_stage.freq[31:0]   <= HOST_DATA;
        A_FREQ_HI:  r_stage.freq[47:32]  <= HOST_DATA[15:0];
        A_DFREQ_LO: r_stage.dfreq[31:0]  <= HOST_DATA;
        A_DFREQ_HI: r_stage.dfreq[47:32] <= HOST_DATA[15:0];
        A_DRATE:    r_stage.drate        <= HOST_DATA;
        A_TS_LO:    r_stage.tstart[31:0] <= HOST_DATA;
        A_TS_HI:    r_stage.tstart[47:32] <= HOST_DATA[15:0];
        A_TYPE_N:   {r_stage.typ, r_stage.n_imp} <= HOST_DATA[17:0];
        A_TI:       r_stage.ti  <= HOST_DATA;
        A_TP:       r_stage.tp  <= HOST_DATA;
        A_TB1:      r_stage.tb1 <= HOST_DATA;
        A_TB2:      r_stage.tb2 <= HOST_DATA;
        default: ;
      endcase
  end
  // issue FSM: WR_DATA and MEM_* load on the edge the issue condition is seen
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_mem   <= '1;
      r_last  <= '0;
      r_wr    <= 1'b0;
      r_ovf   <= 1'b0;
      r_late  <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_wr    <= 1'b0;
      r_stall <= w_pop;
      if (HOST_COMMIT && FULL && !FLUSH) r_ovf <= 1'b1;
      if (FLUSH) r_state <= IDLE;
      else
        case (r_state)
          IDLE: if (!EMPTY) r_state <= WAIT;
          WAIT:
            if (!r_stall) begin
              if (w_late) begin
                r_late <= 1'b1;
                if (w_count == (AW+1)'(1) && !w_push) r_state <= IDLE;
              end else if (w_go) begin
                r_state <= ISSUE;
                r_wr    <= 1'b1;
                r_mem   <= w_head;
                r_last  <= w_head.tstart;
              end
            end
          ISSUE: r_state <= HOLD;
          HOLD: if (w_t > r_last && !BUSY) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
    end
  end
  assign WR_DATA            = r_wr;
  assign MEM_DDS_freq       = r_mem.freq;
  assign MEM_DDS_delta_freq = r_mem.dfreq;
  assign MEM_DDS_delta_rate = r_mem.drate;
  assign MEM_TIME_START     = r_mem.tstart;
  assign MEM_N_impuls       = r_mem.n_imp;
  assign MEM_TYPE_impulse   = r_mem.typ;
  assign MEM_Interval_Ti    = r_mem.ti;
  assign MEM_Interval_Tp    = r_mem.tp;
  assign MEM_Tblank1        = r_mem.tb1;
  assign MEM_Tblank2        = r_mem.tb2;
  assign COUNT              = 3'(w_count);
  assign OVF                = r_ovf;
  assign LATE               = r_late;
endmodule
